// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: decodes VGA sync and pixel stream into coordinates, checks timing, tracks lock
// Pipeline: input stage 0 -> h/v counters and checks -> registered pixel outputs.
module vga_sync_receiver #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BACK      = 48,
    parameter int H_SYNC      = 96,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_BACK      = 33,
    parameter int V_SYNC      = 2,
    parameter int V_TOTAL     = 525,
    parameter bit SYNC_POL    = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pix_en,
    input  logic        Hsync,
    input  logic        Vsync,
    input  logic [7:0]  Red,
    input  logic [7:0]  Green,
    input  logic [7:0]  Blue,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [7:0]  err_count
);
    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [10:0] HT = 11'(H_TOTAL);
    localparam logic [10:0] HS = 11'(H_SYNC);
    localparam logic [10:0] VT = 11'(V_TOTAL);
    localparam logic [10:0] VS = 11'(V_SYNC);
    localparam logic [9:0] H0 = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H1 = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V0 = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V1 = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [7:0] LF = 8'(LOCK_FRAMES);

    logic        hs0, hs1, vs0, vs_line;
    logic [23:0] rgb0, rgb1;
    logic [9:0]  h_cnt, v_cnt;
    logic [10:0] h_nx, v_nx;
    logic [1:0]  state;
    logic [7:0]  good_cnt;
    logic        hs_a, hs_pa, vs_a, lead, trail, fs, any_err;

    assign hs_a  = hs0 == SYNC_POL;
    assign hs_pa = hs1 == SYNC_POL;
    assign vs_a  = vs0 == SYNC_POL;
    assign lead  = hs_a && !hs_pa;
    assign trail = !hs_a && hs_pa;
    // vs_line remembers whether Vsync was asserted at the previous line start
    assign fs    = lead && vs_a && !vs_line;
    assign h_nx  = {1'b0, h_cnt} + 11'd1;
    assign v_nx  = {1'b0, v_cnt} + 11'd1;
    assign any_err = state != S_SEARCH && ((lead && h_nx != HT) || (trail && h_nx != HS) ||
                     (fs && v_nx != VT) || (lead && vs_line && !vs_a && v_nx != VS));
    assign locked = state == S_LOCKED;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hs0         <= !SYNC_POL;
            hs1         <= !SYNC_POL;
            vs0         <= !SYNC_POL;
            vs_line     <= 1'b0;
            rgb0        <= '0;
            rgb1        <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            state       <= S_SEARCH;
            good_cnt    <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            err_count   <= '0;
        end else if (!pix_en) begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
        end else begin
            hs0   <= Hsync;
            hs1   <= hs0;
            vs0   <= Vsync;
            rgb0  <= {Red, Green, Blue};
            rgb1  <= rgb0;
            h_cnt <= lead ? '0 : h_nx[10] ? h_cnt : h_nx[9:0];
            if (lead) begin
                vs_line <= vs_a;
                v_cnt   <= fs ? '0 : v_nx[10] ? v_cnt : v_nx[9:0];
            end
            frame_start <= fs;
            err         <= any_err;
            if (any_err && err_count != 8'hff)
                err_count <= err_count + 8'd1;
            if (any_err) begin
                state    <= S_SEARCH;
                good_cnt <= '0;
            end else if (fs && state == S_SEARCH) begin
                state    <= S_TRACK;
                good_cnt <= '0;
            end else if (fs && state == S_TRACK) begin
                good_cnt <= good_cnt + 8'd1;
                if (good_cnt + 8'd1 == LF)
                    state <= S_LOCKED;
            end
            pix_valid <= state == S_LOCKED && h_cnt >= H0 && h_cnt < H1 && v_cnt >= V0 && v_cnt < V1;
            pix_x     <= h_cnt - H0;
            pix_y     <= v_cnt - V0;
            pix_rgb   <= rgb1;
        end
    end
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: randomized VGA stream against a sample-index reference model
// Uses a scaled-down 30x12 raster so every scenario stays within a short run.
module tb_vga_sync_receiver;
    localparam int HA = 16, HB = 4, HSW = 6, HT = 30;
    localparam int VA = 6, VB = 2, VSW = 2, VT = 12;
    localparam int LOCKF = 2;

    logic        Clk = 1'b0;
    logic        Reset, pix_en, Hsync, Vsync;
    logic [7:0]  Red, Green, Blue;
    logic        pix_valid, frame_start, locked, err;
    logic [9:0]  pix_x, pix_y;
    logic [23:0] pix_rgb;
    logic [7:0]  err_count;

    vga_sync_receiver #(
        .H_ACTIVE(HA), .H_BACK(HB), .H_SYNC(HSW), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_BACK(VB), .V_SYNC(VSW), .V_TOTAL(VT),
        .SYNC_POL(1'b1), .LOCK_FRAMES(LOCKF)
    ) dut (
        .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .Hsync(Hsync), .Vsync(Vsync),
        .Red(Red), .Green(Green), .Blue(Blue), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .pix_rgb(pix_rgb), .frame_start(frame_start), .locked(locked),
        .err(err), .err_count(err_count)
    );

    always #5 Clk = ~Clk;

    int tests = 0, fails = 0;
    int n, last_lead, line_idx, frame_line, st, good, cnt, npix;
    bit prev_ha, prev_vsl;
    logic [63:0] ctrl_q[$], pix_q[$], last_ctrl;
    logic [19:0] first_xy, last_xy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
            if (fails >= 50) begin
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    endtask

    task automatic model_reset();
        n = 0; last_lead = 0; line_idx = 0; frame_line = 0;
        st = 0; good = 0; cnt = 0; prev_ha = 0; prev_vsl = 0;
        ctrl_q = {64'(0)};
        pix_q = {64'(0), 64'(0)};
        last_ctrl = 0;
    endtask

    // Model works on sample indices: line length = distance between Hsync rises, frame length = lines between Vsync rises
    task automatic model_push(input bit ha, input bit va, input logic [23:0] rgb);
        bit lead, trail, fs, e, pv;
        int h, v;
        lead = ha && !prev_ha;
        trail = !ha && prev_ha;
        fs = 0;
        e = 0;
        if (lead) begin
            e = (n - last_lead) != HT;
            line_idx++;
            fs = va && !prev_vsl;
            if (fs) begin
                e = e || (line_idx - frame_line) != VT;
                frame_line = line_idx;
            end else if (prev_vsl && !va)
                e = e || (line_idx - frame_line) != VSW;
            prev_vsl = va;
            last_lead = n;
        end
        if (trail)
            e = e || (n - last_lead) != HSW;
        if (st == 0)
            e = 0;
        if (e) begin
            st = 0; good = 0;
            if (cnt < 255) cnt++;
        end else if (fs && st == 0) begin
            st = 1; good = 0;
        end else if (fs && st == 1) begin
            good++;
            if (good == LOCKF) st = 2;
        end
        prev_ha = ha;
        ctrl_q.push_back(64'({fs, e, st == 2, 8'(cnt)}));
        h = n - last_lead;
        v = line_idx - frame_line;
        pv = st == 2 && h >= HSW + HB && h < HSW + HB + HA && v >= VSW + VB && v < VSW + VB + VA;
        pix_q.push_back(pv ? 64'({1'b1, 10'(h - HSW - HB), 10'(v - VSW - VB), rgb}) : 64'(0));
        n++;
    endtask

    task automatic step(input bit hs, input bit vs, input logic [23:0] rgb, input bit en);
        logic [63:0] ec, ep;
        Hsync = hs; Vsync = vs; {Red, Green, Blue} = rgb; pix_en = en;
        if (en) model_push(hs, vs, rgb);
        @(posedge Clk);
        #1;
        if (en) begin
            ec = ctrl_q.pop_front();
            ep = pix_q.pop_front();
            last_ctrl = ec;
        end else begin
            ec = last_ctrl & 64'h1ff;
            ep = 0;
        end
        check("ctrl", 64'({frame_start, err, locked, err_count}), ec);
        check("pix", pix_valid ? 64'({1'b1, pix_x, pix_y, pix_rgb}) : 64'(0), ep);
        if (pix_valid) begin
            npix++;
            if (npix == 1) first_xy = {pix_x, pix_y};
            last_xy = {pix_x, pix_y};
        end
    endtask

    // mode 0: pix_en always 1; mode 1: alternate 1/0; mode 2: random idle edges
    task automatic line(input int l, input int len, input int hsw, input int mode);
        int x, y;
        logic [23:0] rgb;
        for (int p = 0; p < len; p++) begin
            x = p - HSW - HB;
            y = l - VSW - VB;
            rgb = (x >= 0 && x < HA && y >= 0 && y < VA) ? {8'(x), 8'(y), 8'($urandom)} : 24'($urandom);
            step(p < hsw, l < VSW, rgb, 1'b1);
            if (mode == 1) step(1'($urandom), 1'($urandom), 24'($urandom), 1'b0);
            if (mode == 2) repeat ($urandom_range(0, 2)) step(1'($urandom), 1'($urandom), 24'($urandom), 1'b0);
        end
    endtask

    task automatic frame(input int mode, input int bad, input int blen, input int bhsw);
        npix = 0;
        for (int l = 0; l < VT; l++)
            line(l, l == bad ? blen : HT, l == bad ? bhsw : HSW, mode);
    endtask

    task automatic check_pixels(input string tag);
        check({tag, "_npix"}, 64'(npix), 64'(HA * VA));
        check({tag, "_first"}, 64'(first_xy), 64'(0));
        check({tag, "_last"}, 64'(last_xy), 64'({10'(HA - 1), 10'(VA - 1)}));
    endtask

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL timeout: run did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        Reset = 1'b1; pix_en = 1'b0; Hsync = 1'b0; Vsync = 1'b0;
        Red = 8'd0; Green = 8'd0; Blue = 8'd0;
        npix = 0; first_xy = '1; last_xy = '1;
        repeat (2) @(posedge Clk);
        #1;
        check("reset", 64'({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err, err_count}), 64'(0));
        Reset = 1'b0;
        model_reset();

        frame(0, -1, HT, HSW);
        frame(0, -1, HT, HSW);
        check("lock_before_3rd", 64'(locked), 64'(0));
        frame(0, -1, HT, HSW);
        check("lock_at_3rd", 64'(locked), 64'(1));
        check("cnt_clean", 64'(err_count), 64'(0));
        frame(0, -1, HT, HSW);
        check_pixels("locked");

        frame(0, 5, HT - 1, HSW);
        check("short_cnt", 64'(err_count), 64'(1));
        check("short_unlock", 64'(locked), 64'(0));
        frame(0, -1, HT, HSW);
        frame(0, -1, HT, HSW);
        check("relock_early", 64'(locked), 64'(0));
        frame(0, -1, HT, HSW);
        check("relock", 64'(locked), 64'(1));

        frame(0, 3, HT - 1, HSW - 1);
        check("dual_cnt", 64'(err_count), 64'(2));
        repeat (3) frame(0, -1, HT, HSW);
        check("dual_relock", 64'(locked), 64'(1));

        frame(1, -1, HT, HSW);
        check_pixels("alt_en");
        frame(2, -1, HT, HSW);
        check_pixels("rand_en");
        check("cnt_en", 64'(err_count), 64'(2));

        for (int f = 0; f < 6; f++)
            frame($urandom_range(0, 2), $urandom_range(0, VT - 1), HT - 1 + $urandom_range(0, 2),
                  HSW - 1 + $urandom_range(0, 2));
        repeat (3) frame(0, -1, HT, HSW);
        check("rand_relock", 64'(locked), 64'(1));
        check("rand_cnt", 64'(err_count), 64'(cnt));

        line(3, 13, HSW, 0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("mid_reset", 64'({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err, err_count}), 64'(0));
        Reset = 1'b0;
        model_reset();

        for (int i = 0; i < 300; i++)
            for (int v = 0; v < 2; v++) begin
                step(1'b1, v[0], 24'($urandom), 1'b1);
                repeat (3) step(1'b0, v[0], 24'($urandom), 1'b1);
            end
        check("saturate", 64'(err_count), 64'(255));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
